// File: rtl/leaf_user_pkg.sv
// Shared constants and helpers for the leaf shell user-side port logic.
package leaf_user_pkg;

    localparam int PAYLOAD_BITS_DEFAULT = 32;
    localparam int DEPTH_BITS_DEFAULT   = 4;
    localparam int DEPTH                = 1 << DEPTH_BITS_DEFAULT;
    localparam int FULL_COUNT           = DEPTH;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/user_fifo_ram.sv
// Simple dual-port storage for the user input FIFO: one write port, one registered read port.
module user_fifo_ram
    import leaf_user_pkg::*;
#(
    parameter int DATA_BITS = PAYLOAD_BITS_DEFAULT,
    parameter int ADDR_BITS = DEPTH_BITS_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem [1 << ADDR_BITS];
    logic [DATA_BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/user_in_port_fifo.sv
// First-word-fall-through elastic buffer between a leaf_interface output port and an
// ap_fifo style kernel input, with occupancy and sticky underflow status.
module user_in_port_fifo
    import leaf_user_pkg::*;
#(
    parameter int DATA_BITS    = PAYLOAD_BITS_DEFAULT,
    parameter int DEPTH_BITS   = DEPTH_BITS_DEFAULT,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk_user,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_BITS-1:0]  din_leaf_interface2user,
    input  logic                  vld_interface2user,
    output logic                  ack_user2interface,
    output logic [DATA_BITS-1:0]  dout_user,
    output logic                  empty_n_user,
    input  logic                  read_user,
    output logic [DEPTH_BITS:0]   count,
    output logic                  almost_full,
    output logic                  err_underflow
);

    localparam int CNT_BITS = clog2(1 << DEPTH_BITS) + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT  = CNT_BITS'(1 << DEPTH_BITS);
    localparam logic [CNT_BITS-1:0] AFULL_CNT = CNT_BITS'(AFULL_THRESH);

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  ack_q, ack_d;
    logic                  empty_n_q, empty_n_d;
    logic                  afull_q, afull_d;
    logic                  err_q, err_d;
    logic                  byp_q, byp_d;
    logic [DATA_BITS-1:0]  byp_data_q;
    logic [DATA_BITS-1:0]  ram_rdata;
    logic                  push;
    logic                  pop;

    assign push = vld_interface2user & ack_user2interface;
    assign pop  = empty_n_q & read_user;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        byp_d     = 1'b0;
        err_d     = err_q | (read_user & ~empty_n_q);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // The word being written becomes the head; the RAM read would see stale data.
            byp_d = push && (rd_ptr_d == wr_ptr_q);
        end
        ack_d     = (count_d != FULL_CNT);
        empty_n_d = (count_d != '0);
        afull_d   = (count_d >= AFULL_CNT);
    end

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ack_q      <= 1'b0;
            empty_n_q  <= 1'b0;
            afull_q    <= 1'b0;
            err_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            empty_n_q <= empty_n_d;
            afull_q   <= afull_d;
            err_q     <= err_d;
            byp_q     <= byp_d;
            if (byp_d) begin
                byp_data_q <= din_leaf_interface2user;
            end
        end
    end

    user_fifo_ram #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(DEPTH_BITS)
    ) u_ram (
        .clk_i   (clk_user),
        .rst_n_i (reset_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_leaf_interface2user),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign ack_user2interface = ack_q & ~flush;
    assign dout_user          = byp_q ? byp_data_q : ram_rdata;
    assign empty_n_user       = empty_n_q;
    assign count              = count_q;
    assign almost_full        = afull_q;
    assign err_underflow      = err_q;

endmodule

// File: tb/tb_user_in_port_fifo.sv
// Self-checking bench for user_in_port_fifo: vector table, directed corner sequences,
// and a randomized run against a queue-based occupancy model.
module tb_user_in_port_fifo;

    logic        clk_user = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [31:0] din;
    logic        vld;
    logic        ack;
    logic [31:0] dout;
    logic        empty_n;
    logic        rd;
    logic [4:0]  count;
    logic        almost_full;
    logic        err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    user_in_port_fifo dut (
        .clk_user                (clk_user),
        .reset_n                 (reset_n),
        .flush                   (flush),
        .din_leaf_interface2user (din),
        .vld_interface2user      (vld),
        .ack_user2interface      (ack),
        .dout_user               (dout),
        .empty_n_user            (empty_n),
        .read_user               (rd),
        .count                   (count),
        .almost_full             (almost_full),
        .err_underflow           (err_underflow)
    );

    always #5 clk_user = ~clk_user;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (act=running, req=finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        rd;
        logic [4:0]  cnt;
        logic        en;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        vld = 1'b0; rd = 1'b0; flush = 1'b0; din = '0;
    endtask

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        vld = v; din = d; rd = r; flush = f;
        @(posedge clk_user);
        #1 idle_inputs();
        @(negedge clk_user);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk_user);
        reset_n = 1'b0;
        repeat (3) @(posedge clk_user);
        @(negedge clk_user);
        reset_n = 1'b1;
    endtask

    // Reference model state
    logic [31:0] mq [$];
    logic        m_err;
    logic        m_ack;

    initial begin
        int exp_head [16];
        reset_n = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        chk("rst_ack",   ack, 0);
        chk("rst_en",    empty_n, 0);
        chk("rst_count", count, 0);
        chk("rst_dout",  dout, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_err",   err_underflow, 0);

        tbl[0] = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'hDEADBEEF, 1'b0, 5'd1, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h11,       1'b0, 5'd1, 1'b1, 32'h11};
        tbl[4] = '{1'b1, 32'h22,       1'b1, 5'd1, 1'b1, 32'h22};
        tbl[5] = '{1'b1, 32'h33,       1'b0, 5'd2, 1'b1, 32'h22};
        tbl[6] = '{1'b0, 32'h0,        1'b1, 5'd1, 1'b1, 32'h33};
        tbl[7] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].vld, tbl[i].din, tbl[i].rd, 1'b0);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_en", i), empty_n, tbl[i].en);
            chk($sformatf("tbl%0d_ack", i), ack, 1);
            chk($sformatf("tbl%0d_err", i), err_underflow, 0);
            if (tbl[i].en) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
        end

        // Fill to full, refused 17th word, pop at full, drain
        do_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            chk($sformatf("fill%0d_count", i), count, i + 1);
            chk($sformatf("fill%0d_afull", i), almost_full, (i + 1 >= 12) ? 1 : 0);
            chk($sformatf("fill%0d_ack", i), ack, (i + 1 == 16) ? 0 : 1);
        end
        chk("fill_head", dout, 0);
        step(1'b1, 99, 1'b0, 1'b0);
        chk("full17_count", count, 16);
        step(1'b1, 100, 1'b1, 1'b0);
        chk("popfull_count", count, 15);
        chk("popfull_ack", ack, 1);
        chk("popfull_head", dout, 1);
        step(1'b1, 101, 1'b0, 1'b0);
        chk("refill_count", count, 16);
        for (int i = 0; i < 15; i++) exp_head[i] = i + 1;
        exp_head[15] = 101;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_en", i), empty_n, 1);
            chk($sformatf("drain%0d_dout", i), dout, exp_head[i]);
            step(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drain_count", count, 0);
        chk("drain_en", empty_n, 0);
        chk("drain_err", err_underflow, 0);

        // Streaming at full throughput
        step(1'b1, 1000, 1'b0, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1000 + i, 1'b1, 1'b0);
            chk($sformatf("stream%0d_count", i), count, 1);
            chk($sformatf("stream%0d_dout", i), dout, 1000 + i);
            chk($sformatf("stream%0d_ack", i), ack, 1);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        chk("stream_end_en", empty_n, 0);
        chk("stream_err", err_underflow, 0);

        // Underflow and flush
        step(1'b0, 0, 1'b1, 1'b0);
        chk("uflow_err", err_underflow, 1);
        chk("uflow_count", count, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 200 + i, 1'b0, 1'b0);
        chk("preflush_count", count, 5);
        vld = 1'b1; din = 32'h55; flush = 1'b1; rd = 1'b1;
        #1 chk("flush_ack", ack, 0);
        @(posedge clk_user);
        #1 idle_inputs();
        @(negedge clk_user);
        chk("flush_count", count, 0);
        chk("flush_en", empty_n, 0);
        chk("flush_afull", almost_full, 0);
        chk("flush_err", err_underflow, 1);
        chk("postflush_ack", ack, 1);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        chk("postflush_head", dout, 32'h77);
        chk("postflush_err", err_underflow, 1);

        // Async reset mid-operation
        for (int i = 0; i < 6; i++) step(1'b1, 300 + i, 1'b0, 1'b0);
        chk("prearst_count", count, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_en", empty_n, 0);
        chk("arst_ack", ack, 0);
        chk("arst_count", count, 0);
        chk("arst_err", err_underflow, 0);
        @(negedge clk_user);
        reset_n = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        chk("arst_new_head", dout, 32'hCAFE0001);
        chk("arst_new_count", count, 1);

        // Randomized run against queue model
        do_reset();
        mq.delete();
        m_err = 1'b0;
        m_ack = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  pv, pr;
            logic e_push, e_pop;
            chk("rnd_count", count, mq.size());
            chk("rnd_en", empty_n, (mq.size() > 0) ? 1 : 0);
            chk("rnd_afull", almost_full, (mq.size() >= 12) ? 1 : 0);
            chk("rnd_ack", ack, m_ack);
            chk("rnd_err", err_underflow, m_err);
            if (mq.size() > 0) chk("rnd_dout", dout, mq[0]);
            case ((cyc / 250) % 3)
                0:       begin pv = 80; pr = 30; end
                1:       begin pv = 30; pr = 80; end
                default: begin pv = 60; pr = 60; end
            endcase
            vld   = ($urandom_range(99) < pv);
            rd    = ($urandom_range(99) < pr);
            flush = ($urandom_range(63) == 0);
            din   = $urandom;
            e_push = vld && m_ack && !flush;
            e_pop  = rd && (mq.size() > 0) && !flush;
            if (rd && mq.size() == 0) m_err = 1'b1;
            @(posedge clk_user);
            if (flush) begin
                mq.delete();
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (e_push) mq.push_back(din);
            end
            m_ack = (mq.size() != 16);
            #1 idle_inputs();
            @(negedge clk_user);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
